// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit.
// One FSM sequences FETCH/DECODE and the per-class execute states.
// Datapath controls are registered from the next state, so each control
// is a pure function of the state the FSM is in. The only live terms are
// the fetch/store completion strobes (which depend on mem_ready that
// cycle) and the illegal-opcode flag (which depends on opcode in DECODE).
// BranchNe is captured from opcode on entry to BRANCH; opcode comes from
// the external IR and stays stable for the whole instruction.

module multicycle_control #(
  parameter int MEM_WAIT = 1,
  parameter int JUMP_EN  = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    IMM_EXEC  = 4'd11,
    IMM_WB    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_t cur;
  state_t nxt;
  logic   mem_done;
  logic   op_legal;
  logic   fetch_done;
  logic   pc_write_q;
  logic   done_q;

  // With MEM_WAIT=0 every memory access completes in its first cycle.
  assign mem_done   = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  assign fetch_done = (cur == FETCH) && mem_done;

  // Opcodes the datapath supports; j only when jumps are enabled.
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI: op_legal = 1'b1;
      OP_J:    op_legal = (JUMP_EN != 0);
      default: op_legal = 1'b0;
    endcase
  end

  // Next-state selection; memory states hold until the access completes.
  always_comb begin
    nxt = FETCH;
    case (cur)
      IDLE:      nxt = FETCH;
      FETCH:     nxt = mem_done ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      nxt = R_EXEC;
          OP_LW, OP_SW:  nxt = MEM_ADDR;
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_ADDI:       nxt = IMM_EXEC;
          OP_J:          nxt = (JUMP_EN != 0) ? JUMP : FETCH;
          default:       nxt = FETCH;
        endcase
      end
      MEM_ADDR:  nxt = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  nxt = mem_done ? MEM_WB : MEM_READ;
      MEM_WRITE: nxt = mem_done ? FETCH : MEM_WRITE;
      R_EXEC:    nxt = R_WB;
      IMM_EXEC:  nxt = IMM_WB;
      default:   nxt = FETCH;
    endcase
  end

  // State register, retired-instruction counter and registered controls
  // decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= IDLE;
      instr_count <= '0;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
      PCWriteCond <= 1'b0;
      BranchNe    <= 1'b0;
      IorD        <= 1'b0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      MemtoReg    <= 1'b0;
      RegDst      <= 1'b0;
      RegWrite    <= 1'b0;
      ALUSrcA     <= 1'b0;
      ALUSrcB     <= 2'b00;
      ALUOp       <= 2'b00;
      PCSource    <= 2'b00;
    end else begin
      cur <= nxt;
      if (instr_done) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
      PCWriteCond <= 1'b0;
      BranchNe    <= 1'b0;
      IorD        <= 1'b0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      MemtoReg    <= 1'b0;
      RegDst      <= 1'b0;
      RegWrite    <= 1'b0;
      ALUSrcA     <= 1'b0;
      ALUSrcB     <= 2'b00;
      ALUOp       <= 2'b00;
      PCSource    <= 2'b00;
      case (nxt)
        FETCH: begin
          MemRead <= 1'b1;
          ALUSrcB <= 2'b01;
        end
        DECODE: begin
          ALUSrcB <= 2'b11;
        end
        MEM_ADDR, IMM_EXEC: begin
          ALUSrcA <= 1'b1;
          ALUSrcB <= 2'b10;
        end
        MEM_READ: begin
          MemRead <= 1'b1;
          IorD    <= 1'b1;
        end
        MEM_WB: begin
          RegWrite <= 1'b1;
          MemtoReg <= 1'b1;
          done_q   <= 1'b1;
        end
        MEM_WRITE: begin
          MemWrite <= 1'b1;
          IorD     <= 1'b1;
        end
        R_EXEC: begin
          ALUSrcA <= 1'b1;
          ALUOp   <= 2'b10;
        end
        R_WB: begin
          RegWrite <= 1'b1;
          RegDst   <= 1'b1;
          done_q   <= 1'b1;
        end
        BRANCH: begin
          ALUSrcA     <= 1'b1;
          ALUOp       <= 2'b01;
          PCWriteCond <= 1'b1;
          PCSource    <= 2'b01;
          BranchNe    <= (opcode == OP_BNE);
          done_q      <= 1'b1;
        end
        JUMP: begin
          pc_write_q <= 1'b1;
          PCSource   <= 2'b10;
          done_q     <= 1'b1;
        end
        IMM_WB: begin
          RegWrite <= 1'b1;
          done_q   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes that must follow mem_ready or opcode within the same cycle.
  assign IRWrite    = fetch_done;
  assign PCWrite    = pc_write_q | fetch_done;
  assign instr_done = done_q | ((cur == MEM_WRITE) && mem_done);
  assign illegal_op = (cur == DECODE) && !op_legal;
  assign state      = cur;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have a parameter MEM_WAIT, default 1; 1 means memory states hold until mem_ready=1, and 0 means mem_ready is ignored and each memory state lasts one cycle.
REQ-002 The block SHALL have a parameter JUMP_EN, default 1; 1 means opcode 2 (j) is legal, and 0 means opcode 2 is treated as illegal.
REQ-003 The block SHALL have a parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port opcode, input, 6 bits: instruction[31:26] from the external IR, valid from DECODE onward.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: memory access complete this cycle.
REQ-008 The block SHALL have outputs PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite and ALUSrcA, each 1 bit: datapath controls.
REQ-009 The block SHALL have outputs ALUSrcB, ALUOp and PCSource, each 2 bits: datapath mux and ALU controls.
REQ-010 The block SHALL have output state, 4 bits: current FSM state, for debug.
REQ-011 The block SHALL have output instr_done, 1 bit: one-cycle pulse on the final cycle of each legal instruction.
REQ-012 The block SHALL have output illegal_op, 1 bit: one-cycle pulse when an unsupported opcode is decoded.
REQ-013 The block SHALL have output instr_count, CNT_W bits: retired-instruction count.

Function
REQ-014 The block SHALL implement these states and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, IMM_EXEC=11, IMM_WB=12.
REQ-015 The block SHALL make every datapath output a Moore function of state only; any control not listed for a state SHALL be 0 in that state.
REQ-016 The block SHALL drive IDLE as follows: all controls 0; the next state is FETCH unconditionally.
REQ-017 The block SHALL drive FETCH as follows:
- MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
- IRWrite=1 and PCWrite=1 only in the cycle the fetch completes (mem_ready=1, or always when MEM_WAIT=0).
- On completion, next state is DECODE; otherwise the state holds.
REQ-018 The block SHALL drive DECODE as follows:
- ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- Next state by opcode: 0→R_EXEC, 35 or 43→MEM_ADDR, 4 or 5→BRANCH, 8→IMM_EXEC, 2 with JUMP_EN=1→JUMP.
- Any other opcode→FETCH, with illegal_op=1 for that cycle.
REQ-019 The block SHALL drive MEM_ADDR as follows: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is MEM_READ for opcode 35 and MEM_WRITE for opcode 43.
REQ-020 The block SHALL drive MEM_READ as follows: MemRead=1, IorD=1; it holds until complete, then goes to MEM_WB.
REQ-021 The block SHALL drive MEM_WB as follows: RegWrite=1, MemtoReg=1, RegDst=0; next state is FETCH.
REQ-022 The block SHALL drive MEM_WRITE as follows: MemWrite=1, IorD=1; it holds until complete, then goes to FETCH.
REQ-023 The block SHALL drive R_EXEC as follows: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state is R_WB.
REQ-024 The block SHALL drive R_WB as follows: RegWrite=1, RegDst=1, MemtoReg=0; next state is FETCH.
REQ-025 The block SHALL drive BRANCH as follows: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=(opcode==5); next state is FETCH.
REQ-026 The block SHALL drive JUMP as follows: PCWrite=1, PCSource=10; next state is FETCH.
REQ-027 The block SHALL drive IMM_EXEC as follows: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is IMM_WB.
REQ-028 The block SHALL drive IMM_WB as follows: RegWrite=1, RegDst=0, MemtoReg=0; next state is FETCH.
REQ-029 The block SHALL assert instr_done in these cycles only: MEM_WB, the completing cycle of MEM_WRITE, R_WB, BRANCH, JUMP, IMM_WB.
REQ-030 The block SHALL increment instr_count by 1 on each clock edge where instr_done=1; it wraps modulo 2^CNT_W with no saturation.
REQ-031 The block SHALL ignore mem_ready outside FETCH, MEM_READ and MEM_WRITE.
REQ-032 The block SHALL never assert MemRead and MemWrite in the same cycle.
REQ-033 The block SHALL never assert IRWrite outside FETCH.
REQ-034 The block SHALL produce these cycle counts with MEM_WAIT=0: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2 (FETCH+DECODE).
REQ-035 The block SHALL extend each memory state by the number of cycles mem_ready is held low when MEM_WAIT=1.

Reset
REQ-036 While rst_n=0, the block SHALL immediately (asynchronously) set state=IDLE, all controls 0, instr_done=0, illegal_op=0 and instr_count=0, regardless of clk.
REQ-037 If reset asserts mid-instruction, including during a memory wait, the block SHALL abandon the instruction without incrementing the count; after rst_n rises it SHALL spend one cycle in IDLE, then enter FETCH.

Verification
REQ-038 The bench SHALL cover: MEM_WAIT=0, reset release then opcode=35 → state sequence 0,1,2,3,4,5,1; RegWrite=1 and MemtoReg=1 only in state 5; instr_count=1 afterwards.
REQ-039 The bench SHALL cover: MEM_WAIT=1, opcode=43 with mem_ready low for 3 cycles in MEM_WRITE → MemWrite=1 for 4 cycles; instr_done pulses once, on the fourth cycle.
REQ-040 The bench SHALL cover: opcode=5 → in BRANCH, PCWriteCond=1, BranchNe=1, PCSource=01, ALUOp=01; with opcode=4, BranchNe=0.
REQ-041 The bench SHALL cover: JUMP_EN=0, opcode=2 → DECODE→FETCH with illegal_op=1 for one cycle and instr_count unchanged; with JUMP_EN=1, JUMP is entered with PCWrite=1 and PCSource=10.
REQ-042 The bench SHALL cover: CNT_W=4, 16 R-type instructions → instr_count wraps to 0.
REQ-043 The bench SHALL cover: rst_n pulled low mid-clock during MEM_READ with MEM_WAIT=1 → outputs zero without waiting for a clock edge; IDLE then FETCH after release.
